// File: rtl/led_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_driver_pkg
//  Description : Shared types and constants for the LED driver register block.
//                The register map, MODE bit layout and LEDOUT field encoding
//                are defined here.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_driver_pkg;

    localparam int ADDR_BITS = 3;
    localparam int DATA_BITS = 8;
    localparam int PWM_BITS  = 8;
    localparam int NUM_LEDS  = 4;
    localparam int REG_COUNT = 8;

    localparam logic [DATA_BITS-1:0] REG_RESET_VAL = 8'h00;

    // Register map: every 3-bit address selects a valid register.
    typedef enum logic [ADDR_BITS-1:0] {
        REG_MODE    = 3'd0,
        REG_PWM0    = 3'd1,
        REG_PWM1    = 3'd2,
        REG_PWM2    = 3'd3,
        REG_PWM3    = 3'd4,
        REG_GRPPWM  = 3'd5,
        REG_GRPFREQ = 3'd6,
        REG_LEDOUT  = 3'd7
    } reg_enum_t;

    // MODE register layout, MSB first.
    typedef struct packed {
        logic       auto_increment;  // [7]   stored only
        logic [2:0] reserved;        // [6:4] stored only
        logic       sleep;           // [3]
        logic       dim_blink;       // [2]   0 = dim, 1 = blink
        logic       invert;          // [1]
        logic       output_change;   // [0]   stored only
    } reg_mode_t;

    // Per-LED source selection, two bits per LED in LEDOUT.
    typedef enum logic [1:0] {
        LED_OFF        = 2'd0,
        LED_ON         = 2'd1,
        LED_INDIVIDUAL = 2'd2,
        LED_GROUP      = 2'd3
    } led_out_enum_t;

    // LEDOUT register: field i lives in bits [2i+1:2i].
    typedef led_out_enum_t [NUM_LEDS-1:0] reg_led_out_t;

endpackage
`default_nettype wire

// File: rtl/bus_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_if
//  Description : Register bus between the I2C control block (initiator) and
//                the LED register block (responder). data is a shared
//                bidirectional net: the initiator drives it for writes, the
//                responder drives it for reads.
//  Ports       : addr, r_en, w_en (initiator -> responder); data (inout)
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_if #(
    parameter int ADDR_BITS = led_driver_pkg::ADDR_BITS,
    parameter int DATA_BITS = led_driver_pkg::DATA_BITS
);
    logic [ADDR_BITS-1:0] addr;
    logic                 r_en;
    logic                 w_en;
    wire  [DATA_BITS-1:0] data;

    modport led_ctrl (input addr, input r_en, input w_en, inout data);
    modport i2c_ctrl (output addr, output r_en, output w_en, inout data);
endinterface
`default_nettype wire

// File: rtl/led_pwm_channel.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm_channel
//  Description : Output selection for one LED. Chooses off / on / individual
//                PWM / PWM gated by the group signal, then applies invert.
//  Ports       : i_pwm_cnt  shared PWM counter
//                i_pwm_val  this LED's PWM compare value
//                i_grp_on   group dim/blink gate
//                i_mode     LEDOUT field for this LED
//                i_invert   MODE.invert
//                o_raw      unregistered pin value
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_channel
    import led_driver_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    input  logic [PWM_BITS-1:0] i_pwm_val,
    input  logic                i_grp_on,
    input  led_out_enum_t       i_mode,
    input  logic                i_invert,
    output logic                o_raw
);

    logic w_duty_on;
    logic w_sel;

    // A compare value of 0 never turns on; the maximum value is on for all
    // but the last count of the period.
    assign w_duty_on = (i_pwm_cnt < i_pwm_val);

    always_comb begin
        w_sel = 1'b0;
        case (i_mode)
            LED_OFF:        w_sel = 1'b0;
            LED_ON:         w_sel = 1'b1;
            LED_INDIVIDUAL: w_sel = w_duty_on;
            LED_GROUP:      w_sel = w_duty_on & i_grp_on;
            default:        w_sel = 1'b0;
        endcase
    end

    assign o_raw = w_sel ^ i_invert;

endmodule
`default_nettype wire

// File: rtl/led_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_reg_ctrl
//  Description : Responder on bus_if holding the eight-entry LED register map
//                and generating four LED outputs from per-LED PWM, group
//                dimming/blinking, invert and sleep.
//  Ports       : clk      system clock
//                reset    asynchronous active-high reset
//                sleep    global sleep request (ORed with MODE.sleep)
//                bus      bus_if.led_ctrl responder port
//                led_out  registered LED pin drive, bit i = LEDi
//  Macro       : LED_DRV_PWM_SHADOW_EN - when defined, PWM0-3, GRPPWM and
//                LEDOUT feed the outputs through shadow copies that reload
//                only at the PWM wrap (or while asleep).
//  Revision    : 1.0 - initial release
// ============================================================================
module led_reg_ctrl
    import led_driver_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int GRP_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sleep,
    bus_if.led_ctrl             bus,
    output logic [NUM_LEDS-1:0] led_out
);

    logic [DATA_BITS-1:0] r_regs [REG_COUNT];
    logic [PWM_BITS-1:0]  r_pwm_cnt;
    logic [GRP_BITS-1:0]  r_blink_cnt;
    logic [NUM_LEDS-1:0]  r_led_out;

    reg_mode_t            w_mode;
    logic                 w_asleep;
    logic                 w_wrap;
    logic                 w_grp_on;
    logic                 w_rd_drive;
    logic [NUM_LEDS-1:0]  w_raw;
    logic [DATA_BITS-1:0] w_reg_pwm [NUM_LEDS];
    logic [DATA_BITS-1:0] w_act_pwm [NUM_LEDS];
    logic [DATA_BITS-1:0] w_act_grppwm;
    logic [DATA_BITS-1:0] w_act_ledout;
    reg_led_out_t         w_led_modes;
    logic                 w_unused;

    assign w_mode   = reg_mode_t'(r_regs[REG_MODE]);
    assign w_asleep = sleep | w_mode.sleep;
    assign w_wrap   = (r_pwm_cnt == {PWM_BITS{1'b1}});
    assign w_unused = ^{w_mode.auto_increment, w_mode.reserved, w_mode.output_change};

    // ---------------------------------------------------------------- bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < REG_COUNT; k++) begin
                r_regs[k] <= REG_RESET_VAL;
            end
        end else if (bus.w_en) begin
            r_regs[bus.addr] <= bus.data;
        end
    end

    // A simultaneous write takes priority, so the bus is left to the initiator.
    assign w_rd_drive = bus.r_en & ~bus.w_en & ~reset;
    assign bus.data   = w_rd_drive ? r_regs[bus.addr] : {DATA_BITS{1'bz}};

    // ---------------------------------------------------- active settings
`ifdef LED_DRV_PWM_SHADOW_EN
    logic [DATA_BITS-1:0] r_sh_pwm [NUM_LEDS];
    logic [DATA_BITS-1:0] r_sh_grppwm;
    logic [DATA_BITS-1:0] r_sh_ledout;

    // Reloading only at the period boundary keeps every PWM period whole.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_LEDS; k++) begin
                r_sh_pwm[k] <= REG_RESET_VAL;
            end
            r_sh_grppwm <= REG_RESET_VAL;
            r_sh_ledout <= REG_RESET_VAL;
        end else if (w_asleep || w_wrap) begin
            for (int k = 0; k < NUM_LEDS; k++) begin
                r_sh_pwm[k] <= w_reg_pwm[k];
            end
            r_sh_grppwm <= r_regs[REG_GRPPWM];
            r_sh_ledout <= r_regs[REG_LEDOUT];
        end
    end

    assign w_act_pwm    = r_sh_pwm;
    assign w_act_grppwm = r_sh_grppwm;
    assign w_act_ledout = r_sh_ledout;
`else
    assign w_act_pwm    = w_reg_pwm;
    assign w_act_grppwm = r_regs[REG_GRPPWM];
    assign w_act_ledout = r_regs[REG_LEDOUT];
`endif

    assign w_led_modes = reg_led_out_t'(w_act_ledout);

    // ------------------------------------------------------------ counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt   <= '0;
            r_blink_cnt <= '0;
            r_led_out   <= '0;
        end else if (w_asleep) begin
            r_pwm_cnt   <= '0;
            r_blink_cnt <= '0;
            r_led_out   <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_led_out <= w_raw;
            if (!w_mode.dim_blink) begin
                r_blink_cnt <= '0;
            end else if (w_wrap) begin
                // >= so that lowering GRPFREQ below the count still wraps.
                if (r_blink_cnt >= GRP_BITS'(r_regs[REG_GRPFREQ])) begin
                    r_blink_cnt <= '0;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    assign w_grp_on = w_mode.dim_blink ? (r_blink_cnt < GRP_BITS'(w_act_grppwm))
                                       : (r_pwm_cnt   < PWM_BITS'(w_act_grppwm));

    // ------------------------------------------------------------ channels
    generate
        for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
            localparam logic [ADDR_BITS-1:0] c_pwm_addr = ADDR_BITS'(int'(REG_PWM0) + i);

            assign w_reg_pwm[i] = r_regs[c_pwm_addr];

            led_pwm_channel #(
                .PWM_BITS (PWM_BITS)
            ) u_chan (
                .i_pwm_cnt (r_pwm_cnt),
                .i_pwm_val (PWM_BITS'(w_act_pwm[i])),
                .i_grp_on  (w_grp_on),
                .i_mode    (w_led_modes[i]),
                .i_invert  (w_mode.invert),
                .o_raw     (w_raw[i])
            );
        end
    endgenerate

    assign led_out = r_led_out;

endmodule
`default_nettype wire

// File: tb/tb_led_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_reg_ctrl
//  Description : Directed self-checking bench for led_reg_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_reg_ctrl;
    import led_driver_pkg::*;

    logic       clk;
    logic       reset;
    logic       sleep;
    logic [3:0] led_out;
    logic       drv_en;
    logic [7:0] drv_val;
    int         checks;
    int         errors;
    int         cnt;
    int         per [4];

    bus_if bus_i ();

    assign bus_i.data = drv_en ? drv_val : 8'hzz;

    led_reg_ctrl #(
        .PWM_BITS (8),
        .GRP_BITS (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sleep   (sleep),
        .bus     (bus_i),
        .led_out (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_i.addr = a; bus_i.w_en = 1'b1; bus_i.r_en = 1'b0;
        drv_val = d; drv_en = 1'b1;
        @(negedge clk);
        bus_i.w_en = 1'b0; drv_en = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
        @(negedge clk);
        bus_i.addr = a; bus_i.r_en = 1'b1; bus_i.w_en = 1'b0; drv_en = 1'b0;
        #1;
        check(tag, {24'h0, bus_i.data}, {24'h0, exp});
        bus_i.r_en = 1'b0;
    endtask

    // With r_en low the responder must not fight a value placed by the bench.
    task automatic release_check(input string tag);
        @(negedge clk);
        bus_i.addr = 3'd3; bus_i.r_en = 1'b0; bus_i.w_en = 1'b0;
        drv_val = 8'hA5; drv_en = 1'b1;
        #1;
        check(tag, {24'h0, bus_i.data}, 32'hA5);
        drv_en = 1'b0;
    endtask

    // Sleep pulse: counters restart at 0; sample k afterwards shows pwm_cnt k-1.
    task automatic restart();
        @(negedge clk); sleep = 1'b1;
        @(negedge clk); sleep = 1'b0;
    endtask

    task automatic count_high(input int idx, input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (led_out[idx] === 1'b1) c++;
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; sleep = 1'b0; drv_en = 1'b0; drv_val = 8'h00;
        bus_i.addr = 3'd0; bus_i.r_en = 1'b0; bus_i.w_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_led", {28'h0, led_out}, 32'h0);
        reset = 1'b0;

        // Bus handshake
        write(3'd3, 8'h5A);
        read_check("rd_same_cycle", 3'd3, 8'h5A);
        release_check("release_ren0");
        @(negedge clk);
        bus_i.addr = 3'd3; bus_i.r_en = 1'b1; bus_i.w_en = 1'b1;
        drv_val = 8'hA5; drv_en = 1'b1;
        #1;
        check("rw_undriven", {24'h0, bus_i.data}, 32'hA5);
        @(negedge clk);
        bus_i.r_en = 1'b0; bus_i.w_en = 1'b0; drv_en = 1'b0;
        read_check("rw_written", 3'd3, 8'hA5);

        // Full address decode
        for (int a = 0; a < 8; a++) write(3'(a), 8'(8'h11 * a + 8'h03));
        for (int a = 0; a < 8; a++) read_check("decode", 3'(a), 8'(8'h11 * a + 8'h03));

        // Reset mid-operation
        write(REG_MODE, 8'h00);
        write(REG_PWM0, 8'h80);
        write(REG_LEDOUT, 8'h02);
        restart();
        repeat (5) @(negedge clk);
        check("pre_reset_led", {28'h0, led_out}, 32'h1);
        #2 reset = 1'b1;
        #1 check("reset_mid_led", {28'h0, led_out}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) read_check("reset_regs", 3'(a), 8'h00);
        release_check("reset_release");

        // Individual PWM on LED0
        write(REG_LEDOUT, 8'h02);
        write(REG_PWM0, 8'h40);
        restart(); count_high(0, 256, cnt);
        check("indiv_40", cnt, 64);
        write(REG_PWM0, 8'h00);
        restart(); count_high(0, 256, cnt);
        check("indiv_00", cnt, 0);
        write(REG_PWM0, 8'hFF);
        restart(); count_high(0, 256, cnt);
        check("indiv_ff", cnt, 255);

        // Group dim and invert on LED3
        write(REG_LEDOUT, 8'hC0);
        write(REG_PWM3, 8'hFF);
        write(REG_GRPPWM, 8'h20);
        restart(); count_high(3, 256, cnt);
        check("dim_20", cnt, 32);
        write(REG_MODE, 8'h02);
        restart(); count_high(3, 256, cnt);
        check("dim_20_inv", cnt, 224);
        write(REG_LEDOUT, 8'h40);
        restart(); count_high(3, 256, cnt);
        check("on_inv", cnt, 0);

        // Blink on LED1
        write(REG_MODE, 8'h04);
        write(REG_GRPFREQ, 8'h03);
        write(REG_GRPPWM, 8'h02);
        write(REG_LEDOUT, 8'h0C);
        write(REG_PWM1, 8'hFF);
        restart();
        for (int p = 0; p < 4; p++) count_high(1, 256, per[p]);
        check("blink_p0", per[0], 255);
        check("blink_p1", per[1], 255);
        check("blink_p2", per[2], 0);
        check("blink_p3", per[3], 0);
        write(REG_GRPPWM, 8'h05);
        restart(); count_high(1, 1024, cnt);
        check("blink_always", cnt, 1020);

        // Sleep
        write(REG_MODE, 8'h00);
        write(REG_LEDOUT, 8'h02);
        write(REG_PWM0, 8'h80);
        restart();
        repeat (10) @(negedge clk);
        check("awake_led", {28'h0, led_out}, 32'h1);
        sleep = 1'b1;
        @(negedge clk);
        check("sleep_led", {28'h0, led_out}, 32'h0);
        write(REG_PWM2, 8'h3C);
        read_check("sleep_rw", REG_PWM2, 8'h3C);
        check("sleep_held", {28'h0, led_out}, 32'h0);
        sleep = 1'b0;
        count_high(0, 128, cnt);
        check("wake_high", cnt, 128);
        count_high(0, 128, cnt);
        check("wake_low", cnt, 0);
        write(REG_MODE, 8'h08);
        @(negedge clk);
        check("mode_sleep_led", {28'h0, led_out}, 32'h0);
        read_check("mode_sleep_rd", REG_MODE, 8'h08);
        write(REG_MODE, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_reg_ctrl.md
Name: led_reg_ctrl

Overview:
Responder end of bus_if. It connects through the led_ctrl modport and answers the reads and writes issued by the I2C control block. It holds the eight-entry register map (MODE, PWM0-3, GRPPWM, GRPFREQ, LEDOUT) and generates the four LED outputs from per-LED PWM, group dimming/blinking, invert and sleep. It sits between the I2C control block and the chip's LED pins.

Parameters:
PWM_BITS, 8, width of the PWM counter and PWM compare registers (must equal DATA_BITS).
GRP_BITS, 8, width of the blink-period counter.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
sleep  input  1  global sleep request, ORed with MODE.sleep.
bus  interface  bus_if.led_ctrl  addr[ADDR_BITS-1:0], r_en, w_en in; data[DATA_BITS-1:0] inout.
led_out  output  4  LED pin drive; bit i = LEDi.

Behaviour:
- Reset (async): all eight registers = 8'h00; pwm_cnt = 0; blink_cnt = 0; led_out = 4'b0000; data released (Z).
- Write:
  - w_en=1 at posedge -> reg[addr] <= data.
  - The new value is visible to reads and to output logic from the next cycle.
- Read:
  - While r_en=1 and w_en=0, drive data = reg[addr] combinationally.
  - Otherwise data = 'z.
  - r_en and w_en both 1 -> write performed, data not driven (write wins).
- Address wrap and auto-increment belong to the initiator side; this block decodes addr as given (all 8 codes valid).
- asleep = sleep | MODE.sleep. When asleep:
  - pwm_cnt and blink_cnt held at 0.
  - led_out forced 4'b0000, regardless of invert.
  - Register reads and writes still work.
- pwm_cnt:
  - Free-running 0..255, wraps 255->0. wrap = (pwm_cnt==255).
  - Leaving sleep, counting restarts from 0.
- Group gate grp_on:
  - MODE.dim_blink=0 (dim): grp_on = (pwm_cnt < GRPPWM).
  - MODE.dim_blink=1 (blink): blink_cnt increments on each wrap. When blink_cnt==GRPFREQ on a wrap, it goes to 0. Blink period = (GRPFREQ+1) PWM periods. grp_on = (blink_cnt < GRPPWM).
  - GRPPWM > GRPFREQ -> always on. GRPPWM=0 -> always off.
  - A GRPFREQ write below the current blink_cnt forces blink_cnt to 0 at the next wrap (compare uses >=).
- Per LED i, raw_i is selected by LEDOUT field LEDi:
  - LED_OFF: 0.
  - LED_ON: 1.
  - LED_INDIVIDUAL: pwm_cnt < PWMi.
  - LED_GROUP: (pwm_cnt < PWMi) & grp_on.
- PWMi=0 -> never on; PWMi=255 -> on 255/256 cycles.
- led_out[i] = registered (raw_i ^ MODE.invert), so there is one cycle of latency from counter to pin.
- MODE.output_change, MODE.reserved and MODE.auto_increment are stored and read back only; they have no effect here.

Optional Feature:
LED_DRV_PWM_SHADOW_EN:
- Defined: PWM0-3, GRPPWM and LEDOUT each have an active shadow copy. Shadows load from the written registers only on wrap (or while asleep). Reads return the written value; output logic uses the shadow. This gives glitch-free duty changes. Reset clears the shadows to 0.
- Undefined: output logic uses the registers directly, and a write affects led_out from the second cycle after w_en.

Decomposition:
- Existing in led_driver_pkg: reg_enum_t, reg_mode_t, led_out_enum_t, reg_led_out_t.
- Add to led_driver_pkg: PWM_BITS, NUM_LEDS=4, REG_RESET_VAL=8'h00.
- Sub-module led_pwm_channel, instantiated once per LED. Inputs: pwm_cnt, PWMi, grp_on, LEDOUT field, invert. Output: raw bit.
- Top level holds the register file, counters, bus tristate and output flops.

Test Plan:
- Reset mid-operation: write PWM0=8'h80, LEDOUT=8'h02, then assert reset -> led_out=0 immediately; readback of all addrs = 8'h00; data=Z.
- Bus handshake:
  - w_en addr=3 data=8'h5A, then r_en addr=3 -> data=8'h5A same cycle.
  - r_en=0 -> data=Z.
  - r_en&w_en together -> reg written, data undriven.
- Individual PWM: LEDOUT=8'h02, PWM0=8'h40 -> led_out[0] high exactly 64 of every 256 cycles. PWM0=0 -> always low; PWM0=8'hFF -> low 1 cycle per period.
- Group dim and invert:
  - LEDOUT=8'hC0, PWM3=8'hFF, GRPPWM=8'h20 -> led_out[3] high 32/256 cycles.
  - Set MODE.invert -> high 224/256.
  - LEDOUT field LED_ON with invert -> constant 0.
- Blink:
  - MODE.dim_blink=1, GRPFREQ=3, GRPPWM=2, LEDOUT LED1=LED_GROUP, PWM1=8'hFF -> led_out[1] active 2 of every 4 PWM periods.
  - GRPPWM=5 -> active every period.
- Sleep: during activity raise sleep input (or MODE.sleep=1) -> led_out=0 next cycle and counters frozen at 0. Register write/read still succeed. On release, pwm_cnt restarts at 0.
